// File: rtl/matmul_pkg.sv
// Shared constants and types for the systolic matmul datapath.
package matmul_pkg;

    localparam int MATRIX_SIZE = 4;
    localparam int DATA_WIDTH  = 16;
    localparam int REG_WIDTH   = 16;
    localparam int VECTOR      = 2;
    localparam int BRAM_DEPTH  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } collector_state_t;

    typedef logic [DATA_WIDTH-1:0] elem_t;

endpackage

// File: rtl/lane_delay.sv
// Fixed-depth shift register used to re-align one skewed output lane.
// DEPTH = 0 degenerates to a wire.
module lane_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            // The last lane needs no delay; clock and reset are not used here.
            logic unused_ctrl;
            assign unused_ctrl = clk ^ reset;
            assign dout        = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_reg [DEPTH];

            // Shift the lane one stage per cycle; reset clears every stage.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_reg[i] <= '0;
                    end
                end else begin
                    stage_reg[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                    end
                end
            end

            assign dout = stage_reg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/result_deskew_writer.sv
// Result de-skew and BRAM row writer for the systolic matmul array.
// Lane j of every vector is delayed MATRIX_SIZE-1-j cycles so that a whole
// result row lines up, then one packed row per cycle is written out.
// Optional build macro RESULT_RELU_EN clamps negative elements to zero.
module result_deskew_writer
    import matmul_pkg::*;
#(
    parameter int LATENCY = 2*MATRIX_SIZE-1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [VECTOR*MATRIX_SIZE*DATA_WIDTH-1:0] lane_in,
    output logic                                  wr_en,
    output logic [BRAM_DEPTH-1:0]                 wr_addr,
    output logic [VECTOR*MATRIX_SIZE*REG_WIDTH-1:0] wr_data,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  overrun
);

    localparam int LANES       = VECTOR*MATRIX_SIZE;
    localparam int WAIT_CYCLES = LATENCY + MATRIX_SIZE - 1;
    localparam int CNT_W       = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [BRAM_DEPTH-1:0] ADDR_ONE = BRAM_DEPTH'(1);

    collector_state_t state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic                        wr_en_reg;
    logic [BRAM_DEPTH-1:0]       wr_addr_reg;
    logic [LANES*REG_WIDTH-1:0]  wr_data_reg;
    logic                        busy_reg;
    logic                        done_reg;
    logic                        overrun_reg;

    logic [LANES*REG_WIDTH-1:0]  row_next;

    // Per-lane deskew and element widening into the packed row.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            localparam int J = gi % MATRIX_SIZE;
            logic [DATA_WIDTH-1:0] lane_aligned;

            lane_delay #(
                .DEPTH (MATRIX_SIZE-1-J),
                .WIDTH (DATA_WIDTH)
            ) u_delay (
                .clk   (clk),
                .reset (reset),
                .din   (lane_in[gi*DATA_WIDTH +: DATA_WIDTH]),
                .dout  (lane_aligned)
            );

`ifdef RESULT_RELU_EN
            assign row_next[gi*REG_WIDTH +: REG_WIDTH] =
                lane_aligned[DATA_WIDTH-1] ? '0 : REG_WIDTH'($signed(lane_aligned));
`else
            assign row_next[gi*REG_WIDTH +: REG_WIDTH] = REG_WIDTH'(lane_aligned);
`endif
        end
    endgenerate

    // Sequencer: wait for the first row to align, then drain MATRIX_SIZE rows.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = WAIT;
                    cnt_next   = CNT_W'(WAIT_CYCLES - 1);
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = DRAIN;
                    cnt_next   = CNT_W'(MATRIX_SIZE - 1);
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            DRAIN: begin
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counter and registered outputs; reset aborts immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            wr_en_reg <= (state_next == DRAIN);
            busy_reg  <= (state_next != IDLE);
            done_reg  <= (state_next == DONE);
            // Address steps while draining and parks at zero otherwise.
            if (state_reg == DRAIN && state_next == DRAIN) begin
                wr_addr_reg <= wr_addr_reg + ADDR_ONE;
            end else begin
                wr_addr_reg <= '0;
            end
            // Capture the aligned row the cycle before it is written; hold otherwise.
            if (state_next == DRAIN) begin
                wr_data_reg <= row_next;
            end
            if (start && state_reg != IDLE) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign overrun = overrun_reg;

endmodule

// File: tb/tb_result_deskew_writer.sv
// Directed self-checking bench for result_deskew_writer.
module tb_result_deskew_writer;
    import matmul_pkg::*;

    localparam int M     = MATRIX_SIZE;
    localparam int LANES = VECTOR*M;
    localparam int LAT   = 2*M-1;
    localparam int W_IN  = LANES*DATA_WIDTH;
    localparam int W_OUT = LANES*REG_WIDTH;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [W_IN-1:0]       lane_in;
    logic                  wr_en;
    logic [BRAM_DEPTH-1:0] wr_addr;
    logic [W_OUT-1:0]      wr_data;
    logic                  busy;
    logic                  done;
    logic                  overrun;

    int   n_pass  = 0;
    int   n_total = 0;
    logic exp_overrun = 1'b0;

    always #5 clk = ~clk;

    result_deskew_writer dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .lane_in (lane_in),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .overrun (overrun)
    );

    task automatic chk(input string tag, input logic [W_OUT-1:0] obs, input logic [W_OUT-1:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_WIDTH-1:0] in_elem(input logic [DATA_WIDTH-1:0] base, input int r, input int j);
        return DATA_WIDTH'(int'(base) + 16*r + j);
    endfunction

    function automatic logic [REG_WIDTH-1:0] exp_elem(input logic [DATA_WIDTH-1:0] raw);
`ifdef RESULT_RELU_EN
        if (raw[DATA_WIDTH-1]) return '0;
`endif
        return REG_WIDTH'(raw);
    endfunction

    function automatic logic [W_OUT-1:0] exp_row(input logic [DATA_WIDTH-1:0] b0, input logic [DATA_WIDTH-1:0] b1, input int r);
        logic [W_OUT-1:0] row;
        row = '0;
        for (int v = 0; v < VECTOR; v++) begin
            for (int j = 0; j < M; j++) begin
                row[(v*M+j)*REG_WIDTH +: REG_WIDTH] = exp_elem(in_elem((v == 0) ? b0 : b1, r, j));
            end
        end
        return row;
    endfunction

    // Lane values for cycle k of a run: valid elements on schedule, noise elsewhere.
    task automatic drive_lanes(input logic [DATA_WIDTH-1:0] b0, input logic [DATA_WIDTH-1:0] b1, input int k);
        for (int v = 0; v < VECTOR; v++) begin
            for (int j = 0; j < M; j++) begin
                int r;
                r = k - LAT - j;
                if (r >= 0 && r < M)
                    lane_in[(v*M+j)*DATA_WIDTH +: DATA_WIDTH] = in_elem((v == 0) ? b0 : b1, r, j);
                else
                    lane_in[(v*M+j)*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($urandom);
            end
        end
    endtask

    task automatic idle_cycles(input int n, input bit data_zero);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("idle_wr_en@%0d", i), W_OUT'(wr_en), '0);
            chk($sformatf("idle_busy@%0d", i), W_OUT'(busy), '0);
            chk($sformatf("idle_done@%0d", i), W_OUT'(done), '0);
            chk($sformatf("idle_overrun@%0d", i), W_OUT'(overrun), W_OUT'(exp_overrun));
            if (data_zero) chk($sformatf("idle_wr_data@%0d", i), wr_data, '0);
            start = 1'b0;
            lane_in = {LANES{DATA_WIDTH'($urandom)}};
            tick();
        end
    endtask

    // One tile: cycle k=0 carries the start pulse; returns at cycle 16.
    task automatic run_tile(input logic [DATA_WIDTH-1:0] b0, input logic [DATA_WIDTH-1:0] b1,
                            input int ov_at, input int abort_at);
        logic [REG_WIDTH-1:0] e0;
        logic [REG_WIDTH-1:0] e4;
        for (int k = 0; k <= 15; k++) begin
            bit we;
            if (k > 0 && k-1 == ov_at) exp_overrun = 1'b1;
            we = (k >= 11 && k <= 14);
            chk($sformatf("busy@%0d", k), W_OUT'(busy), W_OUT'(k >= 1 && k <= 15));
            chk($sformatf("done@%0d", k), W_OUT'(done), W_OUT'(k == 15));
            chk($sformatf("wr_en@%0d", k), W_OUT'(wr_en), W_OUT'(we));
            chk($sformatf("wr_addr@%0d", k), W_OUT'(wr_addr), we ? W_OUT'(k-11) : '0);
            chk($sformatf("overrun@%0d", k), W_OUT'(overrun), W_OUT'(exp_overrun));
            if (we) chk($sformatf("wr_data_row%0d", k-11), wr_data, exp_row(b0, b1, k-11));
            if (k == 15) chk("wr_data_hold", wr_data, exp_row(b0, b1, M-1));
            if (b0 == 16'h0000 && k == 12)
                chk("v0_row1_const", W_OUT'(wr_data[63:0]), W_OUT'(64'h0013_0012_0011_0010));
            if (b0 == 16'hFFF0 && k == 11) begin
                e0 = wr_data[15:0];
                e4 = wr_data[4*REG_WIDTH +: REG_WIDTH];
`ifdef RESULT_RELU_EN
                chk("relu_neg", W_OUT'(e0), W_OUT'(16'h0000));
`else
                chk("raw_neg", W_OUT'(e0), W_OUT'(16'hFFF0));
`endif
                chk("pos_five", W_OUT'(e4), W_OUT'(16'h0005));
            end
            if (k == abort_at) begin
                reset = 1'b1;
                exp_overrun = 1'b0;
                #1;
                chk("abort_wr_en", W_OUT'(wr_en), '0);
                chk("abort_busy", W_OUT'(busy), '0);
                chk("abort_done", W_OUT'(done), '0);
                chk("abort_overrun", W_OUT'(overrun), '0);
                start = 1'b0;
                tick();
                chk("abort_held_wr_en", W_OUT'(wr_en), '0);
                reset = 1'b0;
                return;
            end
            start = (k == 0) || (k == ov_at);
            drive_lanes(b0, b1, k);
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        lane_in = '0;
        tick();
        tick();
        chk("rst_wr_en", W_OUT'(wr_en), '0);
        chk("rst_wr_addr", W_OUT'(wr_addr), '0);
        chk("rst_wr_data", wr_data, '0);
        chk("rst_busy", W_OUT'(busy), '0);
        chk("rst_done", W_OUT'(done), '0);
        chk("rst_overrun", W_OUT'(overrun), '0);
        reset = 1'b0;
        tick();

        // Idle with noisy lanes: nothing may be written.
        idle_cycles(20, 1'b1);

        // Basic drain followed by a back-to-back tile.
        run_tile(16'h0000, 16'd100, -1, -1);
        run_tile(16'h0020, 16'h0300, -1, -1);
        idle_cycles(2, 1'b0);

        // Start during WAIT: flagged, ignored, schedule unchanged.
        run_tile(16'h0040, 16'h0500, 5, -1);
        idle_cycles(14, 1'b0);

        // Reset during drain, then a clean run.
        run_tile(16'h1000, 16'h2000, -1, 12);
        idle_cycles(3, 1'b0);
        run_tile(16'h0A00, 16'h0B00, -1, -1);
        idle_cycles(2, 1'b0);

        // Negative and positive elements through the width/clamp path.
        run_tile(16'hFFF0, 16'h0005, -1, -1);
        idle_cycles(2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
